// File: rtl/inst_fetch.sv
// Instruction fetch stage: single-outstanding req/ack fetch from instruction
// memory, a 1-entry skid buffer to absorb a fetch that completes under a
// downstream stall, and redirect handling that drops in-flight stale fetches.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        inst_valid_o
);

    // FULL doubles as the "skid buffer occupied" flag, so no separate bit is kept
    typedef enum logic [1:0] {
        IDLE,
        REQ,
        FLUSH,
        FULL
    } state_t;

    state_t      state_q;
    logic [31:0] fetchPc_q;
    logic [31:0] stalePc_q;
    logic [31:0] bufPc_q;
    logic [31:0] bufInst_q;
    logic [31:0] pc_q;
    logic [31:0] inst_q;
    logic        valid_q;

    logic [31:0] fetchPcInc_d;
    logic [31:0] redirectPc_d;

    assign fetchPcInc_d = fetchPc_q + 32'd4;
    assign redirectPc_d = redirect_pc_i & ~32'h0000_0003;

    // A flushed request keeps presenting its original address until the ack,
    // while fetchPc_q already holds the redirect target
    assign mem_req_o    = (state_q == REQ) || (state_q == FLUSH);
    assign mem_addr_o   = (state_q == FLUSH) ? stalePc_q : fetchPc_q;

    assign pc_o         = pc_q;
    assign inst_o       = inst_q;
    assign inst_valid_o = valid_q;

    // Fetch FSM together with the output register and skid buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            fetchPc_q <= RESET_PC;
            stalePc_q <= 32'd0;
            bufPc_q   <= 32'd0;
            bufInst_q <= NOP_INST;
            pc_q      <= 32'd0;
            inst_q    <= NOP_INST;
            valid_q   <= 1'b0;
        end else if (redirect_valid_i) begin
            valid_q   <= 1'b0;
            inst_q    <= NOP_INST;
            fetchPc_q <= redirectPc_d;
            if (((state_q == REQ) || (state_q == FLUSH)) && !mem_ack_i) begin
                state_q <= FLUSH;
                if (state_q == REQ) begin
                    stalePc_q <= fetchPc_q;
                end
            end else begin
                state_q <= REQ;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= REQ;
                    if (!stall_i) begin
                        inst_q  <= NOP_INST;
                        valid_q <= 1'b0;
                    end
                end
                REQ: begin
                    if (mem_ack_i) begin
                        fetchPc_q <= fetchPcInc_d;
                        if (!stall_i || !valid_q) begin
                            pc_q    <= fetchPc_q;
                            inst_q  <= mem_rdata_i;
                            valid_q <= 1'b1;
                        end else begin
                            bufPc_q   <= fetchPc_q;
                            bufInst_q <= mem_rdata_i;
                            state_q   <= FULL;
                        end
                    end else if (!stall_i) begin
                        inst_q  <= NOP_INST;
                        valid_q <= 1'b0;
                    end
                end
                FLUSH: begin
                    if (mem_ack_i) begin
                        state_q <= REQ;
                    end
                    if (!stall_i) begin
                        inst_q  <= NOP_INST;
                        valid_q <= 1'b0;
                    end
                end
                FULL: begin
                    if (!stall_i) begin
                        pc_q    <= bufPc_q;
                        inst_q  <= bufInst_q;
                        valid_q <= 1'b1;
                        state_q <= REQ;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Randomized bench for inst_fetch: a memory responder with programmable wait
// states, a scoreboard of expected pc values rebuilt on every reset/redirect,
// and a monitor that checks bus, stall and redirect behaviour each cycle.
module tb_inst_fetch;
    localparam logic [31:0] RESET_PC = 32'hFFFF_FFF8;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirValid = 1'b0;
    logic [31:0] redirPc = 32'd0;
    logic        memReq;
    logic [31:0] memAddr;
    logic        memAck = 1'b0;
    logic [31:0] memRdata = 32'd0;
    logic [31:0] pcOut;
    logic [31:0] instOut;
    logic        instValid;

    int checks = 0;
    int failures = 0;
    int consumed = 0;
    int idleCnt = 0;

    logic [31:0] expQ[$];
    logic [31:0] modelPc = RESET_PC;
    bit          modelFull = 1'b0;

    int memLat = 0;
    bit memLatRand = 1'b0;
    int memCnt = 0;
    bit memBusy = 1'b0;

    logic        prevRst = 1'b1;
    logic        prevRedir = 1'b0;
    logic        prevStall = 1'b0;
    logic        prevReq = 1'b0;
    logic        prevAck = 1'b0;
    logic [31:0] prevAddr = 32'd0;
    logic [31:0] prevPc = 32'd0;
    logic [31:0] prevInst = 32'd0;
    logic        prevValid = 1'b0;

    inst_fetch #(
        .RESET_PC(RESET_PC),
        .NOP_INST(NOP_INST)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .stall_i          (stall),
        .redirect_valid_i (redirValid),
        .redirect_pc_i    (redirPc),
        .mem_req_o        (memReq),
        .mem_addr_o       (memAddr),
        .mem_ack_i        (memAck),
        .mem_rdata_i      (memRdata),
        .pc_o             (pcOut),
        .inst_o           (instOut),
        .inst_valid_o     (instValid)
    );

    // Free-running clock
    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] addr);
        return addr | 32'hA000_0000;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drives one cycle's inputs and keeps the expected pc stream topped up
    task automatic applyStimulus(input logic rstV, input logic stallV, input logic redirV, input logic [31:0] addr);
        rst        = rstV;
        stall      = stallV;
        redirValid = redirV;
        redirPc    = addr;
        if (rstV) begin
            expQ.delete();
            modelPc = RESET_PC;
        end else if (redirV) begin
            expQ.delete();
            modelPc = addr & ~32'h3;
        end
        while (expQ.size() < 8) begin
            expQ.push_back(modelPc);
            modelPc = modelPc + 32'd4;
        end
    endtask

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    // Memory responder: acks each request after memLat wait cycles
    initial begin
        forever begin
            @(negedge clk);
            if (memReq) begin
                if (!memBusy) begin
                    memBusy = 1'b1;
                    memCnt  = memLatRand ? int'($urandom_range(0, 3)) : memLat;
                end
                if (memCnt == 0) begin
                    memAck   = 1'b1;
                    memRdata = memWord(memAddr);
                    memBusy  = 1'b0;
                end else begin
                    memAck   = 1'b0;
                    memRdata = $urandom;
                    memCnt--;
                end
            end else begin
                memAck   = 1'b0;
                memBusy  = 1'b0;
                memRdata = $urandom;
            end
        end
    end

    // Monitor: per-cycle protocol checks and scoreboard pops on consumption
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            #3;
            if (prevRst) begin
                checkOutput("resetReq", memReq, 1'b0);
                checkOutput("resetPc", pcOut, 32'd0);
                checkOutput("resetInst", instOut, NOP_INST);
                checkOutput("resetValid", instValid, 1'b0);
            end else begin
                if (prevRedir) begin
                    checkOutput("redirValid", instValid, 1'b0);
                    checkOutput("redirInst", instOut, NOP_INST);
                end
                if (prevReq && !prevAck) begin
                    checkOutput("busHoldReq", memReq, 1'b1);
                    checkOutput("busHoldAddr", memAddr, prevAddr);
                end
                if (prevStall && prevValid && !prevRedir) begin
                    checkOutput("stallPc", pcOut, prevPc);
                    checkOutput("stallInst", instOut, prevInst);
                    checkOutput("stallValid", instValid, 1'b1);
                end
                if (modelFull) begin
                    checkOutput("fullNoReq", memReq, 1'b0);
                end
            end
            if (!instValid) begin
                checkOutput("invalidIsNop", instOut, NOP_INST);
            end
            if (memReq) begin
                checkOutput("addrAligned", {30'd0, memAddr[1:0]}, 32'd0);
            end

            if (!rst && !redirValid && !stall && instValid) begin
                if (expQ.size() == 0) begin
                    checkOutput("scoreboardEmpty", pcOut, 32'hFFFF_FFFF);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("consumePc", pcOut, e);
                    checkOutput("consumeInst", instOut, memWord(e));
                    consumed++;
                end
                idleCnt = 0;
            end else if (rst || redirValid) begin
                idleCnt = 0;
            end else if (!stall) begin
                idleCnt++;
                if (idleCnt > 40) begin
                    checkOutput("liveness", idleCnt, 32'd0);
                    idleCnt = 0;
                end
            end

            if (rst || redirValid) begin
                modelFull = 1'b0;
            end else if (modelFull) begin
                modelFull = stall;
            end else begin
                modelFull = stall && instValid && memReq && memAck;
            end

            prevRst   = rst;
            prevRedir = redirValid;
            prevStall = stall;
            prevReq   = memReq;
            prevAck   = memAck;
            prevAddr  = memAddr;
            prevPc    = pcOut;
            prevInst  = instOut;
            prevValid = instValid;
        end
    end

    // Directed phases followed by a long randomized run
    initial begin
        logic [31:0] staleAddr;
        bit found;

        // Reset, first request latency and zero-wait streaming across the wrap
        memLat = 0;
        step(); applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
        step(); applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
        step();
        checkOutput("idleNoReq", memReq, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
        step();
        checkOutput("firstReq", memReq, 1'b1);
        checkOutput("firstAddr", memAddr, RESET_PC);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
        step();
        checkOutput("firstValid", instValid, 1'b1);
        checkOutput("firstPc", pcOut, RESET_PC);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
            step();
            checkOutput("streamValid", instValid, 1'b1);
        end

        // Three wait states per fetch
        memLat = 3;
        for (int i = 0; i < 30; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
            step();
        end

        // Stall mid-stream so one fetch lands in the skid buffer
        memLat = 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
            step();
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
            step();
            if (i == 1) begin
                checkOutput("stallFullNoReq", memReq, 1'b0);
            end
        end
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
            step();
        end

        // Redirect while a request is waiting for its ack
        memLat = 2;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (memReq && !memAck) begin
                found = 1'b1;
            end else begin
                applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
                step();
            end
        end
        checkOutput("waitReqFound", found, 1'b1);
        staleAddr = memAddr;
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0103);
        step();
        checkOutput("flushValidLow", instValid, 1'b0);
        checkOutput("flushReq", memReq, 1'b1);
        checkOutput("flushAddr", memAddr, staleAddr);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
            step();
            if (memReq && memAddr != staleAddr) begin
                found = 1'b1;
                checkOutput("redirTarget", memAddr, 32'h0000_0100);
            end
        end
        checkOutput("redirTargetSeen", found, 1'b1);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
            step();
        end

        // Redirect under stall with the buffer full: the flush wins
        memLat = 0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
            step();
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
        step();
        checkOutput("bufFullNoReq", memReq, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_2000);
        step();
        checkOutput("flushWinsValid", instValid, 1'b0);
        checkOutput("flushWinsReq", memReq, 1'b1);
        checkOutput("flushWinsAddr", memAddr, 32'h0000_2000);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
            step();
        end

        // Randomized traffic: wait states, stalls, redirects and resets
        memLatRand = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            applyStimulus(($urandom % 1000) < 5, ($urandom % 100) < 30,
                          ($urandom % 100) < 4, $urandom);
            step();
        end

        // Reset while a request is outstanding
        memLatRand = 1'b0;
        memLat = 3;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
            step();
            if (memReq && !memAck) begin
                found = 1'b1;
            end
        end
        checkOutput("midReqFound", found, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
        step();
        checkOutput("midResetReq", memReq, 1'b0);
        checkOutput("midResetValid", instValid, 1'b0);
        checkOutput("midResetPc", pcOut, 32'd0);
        checkOutput("midResetInst", instOut, NOP_INST);
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
            step();
        end

        checkOutput("enoughOutput", (consumed > 100) ? 32'd1 : 32'd0, 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop if the run ever gets stuck
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction fetch stage. Drives instruction memory through a single-outstanding req/ack bus and produces the pc/inst pair that the decode stage consumes.
- Holds its output under downstream stall using a 1-entry skid buffer.
- Accepts branch/jump redirects from execute and discards any in-flight fetch that a redirect makes stale.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset (must be 4-aligned)
NOP_INST, 32'h0000_0013, instruction emitted when no valid instruction (addi x0,x0,0)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, synchronous, active-high
stall_i  in  1  downstream stall; output pair not consumed this edge
redirect_valid_i  in  1  single-cycle redirect request
redirect_pc_i  in  32  redirect target; bits [1:0] ignored, forced 0
mem_req_o  out  1  fetch request
mem_addr_o  out  32  fetch address, 4-aligned
mem_ack_i  in  1  request completes this cycle; mem_rdata_i valid
mem_rdata_i  in  32  fetched instruction word
pc_o  out  32  pc of inst_o, to decode
inst_o  out  32  instruction word, to decode
inst_valid_o  out  1  pc_o/inst_o hold a real instruction

Behaviour:
- Reset (rst=1 at edge):
  - state=IDLE, fetch_pc=RESET_PC, buffer empty, discard=0.
  - pc_o=0, inst_o=NOP_INST, inst_valid_o=0.
  - mem_req_o=0 while state is IDLE.
- Reset during an outstanding request abandons it. mem_req_o is 0 on the cycle after the reset edge. Any mem_ack_i seen in IDLE is ignored.
- States:
  - IDLE: mem_req_o=0. Always goes to REQ at the next edge.
  - REQ: mem_req_o=1, mem_addr_o=fetch_pc.
  - FLUSH: mem_req_o=1, mem_addr_o=the stale address; the returned data will be dropped.
  - FULL: mem_req_o=0; the buffer holds one instruction.
- Bus rule: once mem_req_o is raised, mem_addr_o stays stable until the edge where mem_ack_i=1. The ack may arrive in the same cycle as the request (zero-wait). mem_rdata_i is sampled only on that edge.
- Consume rule: the output pair is consumed at every edge where stall_i=0. At such an edge the output register loads, in this priority:
  1. the buffer, if full;
  2. otherwise the accepted mem_rdata_i with its fetch_pc;
  3. otherwise NOP_INST with inst_valid_o=0 (pc_o holds).
- While stall_i=1, pc_o/inst_o/inst_valid_o hold.
- REQ, ack, no redirect:
  - fetch_pc += 4 (mod 2^32; 32'hFFFF_FFFC wraps to 0).
  - If stall_i=0 and buffer empty: data goes to the output; stay in REQ. This gives back-to-back requests, one instruction per cycle with zero-wait memory.
  - If stall_i=1: if inst_valid_o=0, data goes directly to the output and state stays REQ. Otherwise data goes into the buffer and state goes to FULL.
- FULL: when stall_i=0, buffer moves to output, buffer empties, state goes to REQ.
- Redirect (redirect_valid_i=1 at edge) has highest priority and overrides stall_i:
  - inst_valid_o<=0, inst_o<=NOP_INST, buffer cleared.
  - fetch_pc<={redirect_pc_i[31:2],2'b00}.
  - If state=REQ/FLUSH and no ack this edge: state goes to FLUSH (discard=1), and the old request continues.
  - If an ack arrives on the same edge as the redirect: the data is dropped and state goes to REQ.
  - From IDLE/FULL: state goes to REQ.
- FLUSH, ack: data dropped, fetch_pc unchanged, state goes to REQ. A second redirect while in FLUSH only updates fetch_pc.
- No ack timeout. mem_req_o holds indefinitely.
- Latency:
  - First mem_req_o=1 one cycle after rst deasserts.
  - With zero-wait ack and no stall, inst_valid_o=1 on the edge after the first ack.

Test Plan:
- Reset then run with zero-wait memory returning word = addr|32'hA000_0000, stall_i=0. Expect:
  - mem_addr_o 0,4,8,… on consecutive cycles;
  - pc_o/inst_o = 0/A000_0000, 4/A000_0004, … with inst_valid_o=1 continuously from the 2nd cycle after reset.
- Ack 3 cycles after each request. Expect:
  - mem_addr_o stable across the wait cycles;
  - inst_valid_o pulses 1 for one cycle per fetch and inst_o=NOP_INST between fetches.
- Hold stall_i=1 for 4 cycles mid-stream at pc_o=8. Expect:
  - pc_o/inst_o hold 8/A000_0008;
  - the fetch for 12 goes into the buffer and mem_req_o=0 while FULL;
  - after stall drops: pc_o=12, then 16; no instruction lost or duplicated.
- Redirect to 32'h0000_0103 while the request for 20 waits 2 cycles for ack. Expect:
  - inst_valid_o=0 on the next cycle;
  - mem_addr_o stays 20 until ack and that data is never output;
  - next request address is 32'h0000_0100; pc_o=0x100 appears with valid=1.
- Redirect with stall_i=1 and buffer full. Expect flush wins: inst_valid_o=0, buffer cleared, next fetch at the redirect target.
- RESET_PC=32'hFFFF_FFF8, zero-wait memory. Expect pc_o FFFF_FFF8, FFFF_FFFC, 0000_0000. Then assert rst mid-request: mem_req_o=0 on the next cycle, outputs back to reset values.
